// File: rtl/pair_pattern_gen.sv
// Pair pattern generator for the memory game: draws six distinct switch positions 0..14
// from a free-running LFSR and falls back to a lowest-unused fill when draws run out.
module pair_pattern_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [7:0]  MAX_DRAWS = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       genReq,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [3:0] F,
  output logic       patternValid,
  output logic       patternDone,
  output logic       busy
);

  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {StIdle, StDraw, StFill, StLatch} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  slot_q [6];
  logic [3:0]  out_q  [6];
  logic [2:0]  idx_q;
  logic [14:0] used_q;
  logic [7:0]  cnt_q, cnt_inc;
  logic        valid_q, done_q;
  logic [3:0]  cand, fill_idx;
  logic [15:0] used_ext;
  logic        accept;

  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign cand     = lfsr_q[3:0];
  // Bit 15 is permanently "used" so candidate 15 is rejected by the same lookup.
  assign used_ext = {1'b1, used_q};
  assign accept   = ~used_ext[cand];
  assign cnt_inc  = (cnt_q == MAX_DRAWS) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    fill_idx = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (!used_q[i]) fill_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (genReq) state_d = (MAX_DRAWS == 8'd0) ? StFill : StDraw;
      end
      StDraw: begin
        if (accept && idx_q == 3'd5)   state_d = StLatch;
        else if (cnt_inc == MAX_DRAWS) state_d = StFill;
      end
      StFill: begin
        if (idx_q == 3'd5) state_d = StLatch;
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 3'd0;
      used_q  <= 15'd0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        slot_q[i] <= 4'd0;
        out_q[i]  <= 4'(i);
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (genReq) begin
            idx_q   <= 3'd0;
            used_q  <= 15'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
          end
        end
        StDraw: begin
          cnt_q <= cnt_inc;
          if (accept) begin
            slot_q[idx_q] <= cand;
            used_q        <= used_q | 15'(16'd1 << cand);
            idx_q         <= idx_q + 3'd1;
          end
        end
        StFill: begin
          slot_q[idx_q] <= fill_idx;
          used_q        <= used_q | 15'(16'd1 << fill_idx);
          idx_q         <= idx_q + 3'd1;
        end
        StLatch: begin
          for (int i = 0; i < 6; i++) out_q[i] <= slot_q[i];
          valid_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != StIdle);
    patternValid = valid_q;
    patternDone  = done_q;
    A            = out_q[0];
    B            = out_q[1];
    C            = out_q[2];
    D            = out_q[3];
    E            = out_q[4];
    F            = out_q[5];
  end

endmodule

// File: tb/tb_pair_pattern_gen.sv
// Bench for pair_pattern_gen: random requests scored against a round-level model of the
// LFSR draw/accept/fill rules, plus reset, fill-only, busy-ignore and back-to-back rounds.
module tb_pair_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       req0, req1, req2;
  logic [3:0] o0 [6];
  logic [3:0] o1 [6];
  logic [3:0] o2 [6];
  logic       valid0, done0, busy0, valid1, done1, busy1, valid2, done2, busy2;
  logic [23:0] pat0, pat1, pat2;

  assign pat0 = {o0[0], o0[1], o0[2], o0[3], o0[4], o0[5]};
  assign pat1 = {o1[0], o1[1], o1[2], o1[3], o1[4], o1[5]};
  assign pat2 = {o2[0], o2[1], o2[2], o2[3], o2[4], o2[5]};

  pair_pattern_gen dut (
    .clk(clk), .rst(rst), .genReq(req0),
    .A(o0[0]), .B(o0[1]), .C(o0[2]), .D(o0[3]), .E(o0[4]), .F(o0[5]),
    .patternValid(valid0), .patternDone(done0), .busy(busy0)
  );

  pair_pattern_gen #(.MAX_DRAWS(8'd0)) u_fill (
    .clk(clk), .rst(rst), .genReq(req1),
    .A(o1[0]), .B(o1[1]), .C(o1[2]), .D(o1[3]), .E(o1[4]), .F(o1[5]),
    .patternValid(valid1), .patternDone(done1), .busy(busy1)
  );

  // After one shift 16'h001E becomes 16'h000F, so the first draw sees candidate 15.
  pair_pattern_gen #(.SEED(16'h001E), .MAX_DRAWS(8'd1)) u_one (
    .clk(clk), .rst(rst), .genReq(req2),
    .A(o2[0]), .B(o2[1]), .C(o2[2]), .D(o2[3]), .E(o2[4]), .F(o2[5]),
    .patternValid(valid2), .patternDone(done2), .busy(busy2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Free-running reference LFSR for the default instance.
  logic [15:0] m_lfsr0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr0 <= 16'hACE1;
    else     m_lfsr0 <= lfsr_step(m_lfsr0);
  end

  // Whole round from the LFSR value seen in the first DRAW cycle; lat counts edges after the
  // request edge up to the one that raises patternDone.
  function automatic logic [23:0] model_pat(input logic [15:0] l0, input int maxd,
                                            output int lat);
    logic [15:0] l;
    logic [14:0] used;
    logic [23:0] p;
    int n, draws;
    bit found;
    l = l0; used = '0; p = '0; n = 0; draws = 0; lat = 0;
    while (n < 6 && draws < maxd) begin
      if (l[3:0] != 4'hF && !used[l[3:0]]) begin
        p = {p[19:0], l[3:0]};
        used[l[3:0]] = 1'b1;
        n++;
      end
      draws++;
      lat++;
      l = lfsr_step(l);
    end
    while (n < 6) begin
      found = 0;
      for (int i = 0; i < 15; i++) begin
        if (!found && !used[i]) begin
          p = {p[19:0], 4'(i)};
          used[i] = 1'b1;
          found = 1;
        end
      end
      n++;
      lat++;
    end
    lat++;
    return p;
  endfunction

  function automatic bit distinct_ok(input logic [23:0] p);
    logic [15:0] seen;
    logic [3:0] v;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      v = p[i*4 +: 4];
      if (v == 4'hF || seen[v]) return 0;
      seen[v] = 1'b1;
    end
    return 1;
  endfunction

  // Waits for patternDone on the default instance; outputs must hold and busy stay high.
  task automatic wait_done(input bit pulse, output int lat, output bit ok);
    logic [23:0] prev;
    prev = pat0;
    ok   = 1;
    lat  = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done0) begin
        if (pat0 !== prev || valid0 !== 1'b0 || busy0 !== 1'b1) ok = 0;
        if (pulse) req0 = lat[0];
      end
    end while (!done0 && lat < 200);
    if (pulse) req0 = 1'b0;
  endtask

  int lat, elat, ndone;
  bit ok;
  logic [23:0] exp_pat;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_pat", pat0, 24'h012345);
    check_eq("reset_valid", valid0, 0);
    check_eq("reset_busy", busy0, 0);
    check_eq("reset_done", done0, 0);

    // MAX_DRAWS=1 instance: request on the first edge after reset release.
    req2 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done2 && lat < 100);
    check_eq("one_lat", lat, 8);
    check_eq("one_pat", pat2, 24'h012345);
    check_eq("one_valid", valid2, 1);

    // Fill-only instance.
    req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done1 && lat < 100);
    check_eq("fill_lat", lat, 7);
    check_eq("fill_pat", pat1, 24'h012345);
    check_eq("fill_valid", valid1, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("fill_valid_hold", valid1, 1);
    check_eq("fill_done_pulse", done1, 0);

    // Random requests at random idle gaps.
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 5)) begin
        @(posedge clk); #1;
      end
      req0 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0;
      exp_pat = model_pat(m_lfsr0, 64, elat);
      wait_done(1'b0, lat, ok);
      check_eq("rnd_lat", lat, elat);
      check_eq("rnd_pat", pat0, exp_pat);
      check_eq("rnd_distinct", distinct_ok(pat0), 1);
      check_eq("rnd_stable", ok, 1);
      check_eq("rnd_valid", valid0, 1);
      check_eq("rnd_busy_low", busy0, 0);
    end

    // genReq pulsed while busy must be ignored.
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    exp_pat = model_pat(m_lfsr0, 64, elat);
    wait_done(1'b1, lat, ok);
    check_eq("busy_lat", lat, elat);
    check_eq("busy_pat", pat0, exp_pat);
    check_eq("busy_stable", ok, 1);
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 || busy0) ndone++;
    end
    check_eq("busy_no_extra", ndone, 0);

    // genReq held high: back-to-back rounds.
    req0 = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      exp_pat = model_pat(m_lfsr0, 64, elat);
      wait_done(1'b0, lat, ok);
      check_eq("hold_lat", lat, elat);
      check_eq("hold_gap", (lat + 1 >= 8), 1);
      check_eq("hold_pat", pat0, exp_pat);
      check_eq("hold_stable", ok, 1);
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DRAW.
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy", busy0, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("async_pat", pat0, 24'h012345);
    check_eq("async_valid", valid0, 0);
    check_eq("async_busy", busy0, 0);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 || busy0) ndone++;
    end
    check_eq("post_reset_idle", ndone, 0);
    check_eq("post_reset_pat", pat0, 24'h012345);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
